// File: rtl/rsff_cmd_arbiter.sv
// Round-robin arbiter sharing a bank of RS flip-flops between requesters.
// Each grant drives a timed S or R pulse, then a guard/readback cycle with ack.
module rsff_cmd_arbiter #(
  parameter int NREQ      = 4,
  parameter int NFLAGS    = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               cmd,
  input  logic [NREQ*$clog2(NFLAGS)-1:0] idx,
  input  logic [NFLAGS-1:0]             q_in,
  output logic [NFLAGS-1:0]             S,
  output logic [NFLAGS-1:0]             R,
  output logic [NREQ-1:0]               ack,
  output logic                          err,
  output logic                          busy
);

  localparam int IW = $clog2(NFLAGS);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PULSE_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_CHECK
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_rr;
  logic [PW-1:0]     r_gnt;
  logic [PW-1:0]     w_gid;
  logic              w_any;
  logic              r_cmd;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic              w_cnt_done;
  logic              w_sel_cmd;
  logic [IW-1:0]     w_sel_idx;
  logic              w_sel_ok;
  logic              w_chk_ok;
  logic              w_drive;
  logic [NFLAGS-1:0] w_onehot;
  logic [NFLAGS-1:0] w_s_nxt;
  logic [NFLAGS-1:0] w_r_nxt;
  logic [NFLAGS-1:0] r_s;
  logic [NFLAGS-1:0] r_r;

  // Indices beyond the bank only exist when NFLAGS is not a power of two.
  if ((1 << IW) == NFLAGS) begin : g_pow2
    assign w_sel_ok = 1'b1;
    assign w_chk_ok = 1'b1;
  end else begin : g_np2
    assign w_sel_ok = (int'(w_sel_idx) < NFLAGS);
    assign w_chk_ok = (int'(r_idx) < NFLAGS);
  end

  assign w_cnt_done = (int'(r_cnt) == PULSE_CYC - 1);

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    int k;
    k     = 0;
    w_any = 1'b0;
    w_gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(r_rr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!w_any && req[k]) begin
        w_any = 1'b1;
        w_gid = PW'(k);
      end
    end
  end

  // Next state and the command that the next cycle will drive.
  always_comb begin
    w_next    = r_state;
    w_sel_cmd = r_cmd;
    w_sel_idx = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next    = ST_PULSE;
          w_sel_cmd = cmd[w_gid];
          w_sel_idx = idx[w_gid*IW +: IW];
        end
      end
      ST_PULSE: begin
        if (w_cnt_done) w_next = ST_CHECK;
      end
      ST_CHECK: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_drive  = (w_next == ST_PULSE) && w_sel_ok;
  assign w_onehot = {{(NFLAGS-1){1'b0}}, 1'b1} << w_sel_idx;
  assign w_s_nxt  = (w_drive && w_sel_cmd)  ? w_onehot : '0;
  assign w_r_nxt  = (w_drive && !w_sel_cmd) ? w_onehot : '0;

  // State, pulse counter and registered bank drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_r     <= '0;
    end else begin
      r_state <= w_next;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      if (r_state == ST_PULSE && !w_cnt_done)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
    end
  end

  // Grant latch at arbitration and pointer advance after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr  <= '0;
      r_gnt <= '0;
      r_cmd <= 1'b0;
      r_idx <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_gnt <= w_gid;
        r_cmd <= w_sel_cmd;
        r_idx <= w_sel_idx;
      end
      if (r_state == ST_CHECK) begin
        if (int'(r_gnt) == NREQ - 1)
          r_rr <= '0;
        else
          r_rr <= r_gnt + PW'(1);
      end
    end
  end

  // Acknowledge and readback compare, only during the guard cycle.
  always_comb begin
    ack = '0;
    err = 1'b0;
    if (r_state == ST_CHECK) begin
      ack[r_gnt] = 1'b1;
      err = !w_chk_ok || (q_in[r_idx] != r_cmd);
    end
  end

  assign S    = r_s;
  assign R    = r_r;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rsff_cmd_arbiter.sv
// Bench for rsff_cmd_arbiter: directed table, corner sequences,
// randomized transactions against a transaction-level model.
module tb_rsff_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int NF   = 8;
  localparam int PC   = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = '0;
  logic [3:0]  cmd   = '0;
  logic [11:0] idx   = '0;
  logic [7:0]  fz    = '0;
  logic [7:0]  bank  = '0;
  logic [7:0]  q_in;
  logic [7:0]  S;
  logic [7:0]  R;
  logic [3:0]  ack;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  cmd;
    logic [11:0] idx;
    logic [7:0]  fz;
    int          eg;
    bit          eerr;
  } vec_t;

  vec_t vt[8];

  rsff_cmd_arbiter #(
    .NREQ(NREQ),
    .NFLAGS(NF),
    .PULSE_CYC(PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .cmd(cmd),
    .idx(idx),
    .q_in(q_in),
    .S(S),
    .R(R),
    .ack(ack),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RS flip-flop bank; fz forces readback bits to 0.
  always @(posedge clk) begin
    if (rst_n) bank <= (bank | S) & ~R;
  end
  assign q_in = bank & ~fz;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Bank safety invariants every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_s_and_r", {31'b0, |(S & R)}, 0);
      chk("inv_onehot_sr", {31'b0, $onehot0(S | R)}, 1);
      chk("inv_onehot_ack", {31'b0, $onehot0(ack)}, 1);
      chk("inv_err_no_ack", {31'b0, err && (ack == 0)}, 0);
    end
  end

  // One arbitration window from an IDLE cycle back to the next IDLE cycle.
  task automatic txn(input logic [3:0] rq, input logic [3:0] cm,
                     input logic [11:0] ix, input logic [7:0] f,
                     input int eg, input bit eerr, input bit scr);
    logic [7:0] es;
    logic [7:0] er;
    logic       ec;
    int         fi;
    req = rq;
    cmd = cm;
    idx = ix;
    fz  = f;
    if (eg < 0) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_sr", {16'b0, S, R}, 0);
      return;
    end
    ec = cm[eg];
    fi = int'(ix[eg*3 +: 3]);
    es = ec ? (8'b1 << fi) : 8'b0;
    er = ec ? 8'b0 : (8'b1 << fi);
    for (int p = 0; p < PC; p++) begin
      @(posedge clk); #1;
      if (scr) begin
        req = 4'($urandom);
        cmd = 4'($urandom);
        idx = 12'($urandom);
      end
      chk("pulse_s", {24'b0, S}, {24'b0, es});
      chk("pulse_r", {24'b0, R}, {24'b0, er});
      chk("pulse_busy", {31'b0, busy}, 1);
      chk("pulse_ack", {28'b0, ack}, 0);
    end
    @(posedge clk); #1;
    chk("check_ack", {28'b0, ack}, 32'(4'b1 << eg));
    chk("check_err", {31'b0, err}, {31'b0, eerr});
    chk("check_guard_sr", {16'b0, S, R}, 0);
    chk("check_bank", {31'b0, bank[fi]}, {31'b0, ec});
    @(posedge clk); #1;
    chk("post_idle_busy", {31'b0, busy}, 0);
    chk("post_idle_ack", {28'b0, ack}, 0);
    m_rr = (eg + 1) % NREQ;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int ids[5];
    int cyc[5];
    int na;
    int eg;
    int fi;
    bit eerr;
    logic [3:0]  rq;
    logic [3:0]  cm;
    logic [11:0] ix;
    logic [7:0]  f;

    vt[0] = '{4'b1011, 4'b1111, pk(2, 1, 0, 7), 8'h00, 0, 1'b0};
    vt[1] = '{4'b0010, 4'b0010, pk(0, 3, 0, 0), 8'h00, 1, 1'b0};
    vt[2] = '{4'b1111, 4'b0000, pk(4, 5, 6, 7), 8'h00, 2, 1'b0};
    vt[3] = '{4'b1111, 4'b0000, pk(4, 5, 6, 7), 8'h00, 3, 1'b0};
    vt[4] = '{4'b0001, 4'b0001, pk(5, 0, 0, 0), 8'h20, 0, 1'b1};
    vt[5] = '{4'b1001, 4'b1000, pk(1, 0, 0, 0), 8'h00, 3, 1'b0};
    vt[6] = '{4'b0000, 4'b0000, 12'h000, 8'h00, -1, 1'b0};
    vt[7] = '{4'b0100, 4'b0000, pk(0, 0, 5, 0), 8'h20, 2, 1'b0};

    // Reset held with every requester active.
    req = 4'b1111;
    cmd = 4'b0000;
    idx = pk(1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", {24'b0, S}, 0);
    chk("rst_r", {24'b0, R}, 0);
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst_n = 1'b1;

    // Contention: acks 0,1,2,3,0 spaced by PC+2 cycles.
    na = 0;
    for (int c = 1; c <= 40 && na < 5; c++) begin
      @(posedge clk); #1;
      if (ack != 0) begin
        for (int k = 0; k < NREQ; k++)
          if (ack[k]) ids[na] = k;
        cyc[na] = c;
        na++;
      end
    end
    req = 4'b0000;
    chk("cont_count", na, 5);
    if (na == 5) begin
      chk("cont_first_lat", cyc[0], PC + 1);
      for (int j = 0; j < 5; j++)
        chk("cont_order", ids[j], j % NREQ);
      for (int j = 1; j < 5; j++)
        chk("cont_period", cyc[j] - cyc[j-1], PC + 2);
    end
    @(posedge clk); #1;

    // Async reset in the middle of a pulse.
    req = 4'b0100;
    cmd = 4'b0000;
    idx = pk(0, 0, 3, 0);
    @(posedge clk); #1;
    chk("mid_pulse_r", {24'b0, R}, 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s", {24'b0, S}, 0);
    chk("arst_r", {24'b0, R}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_ack", {28'b0, ack}, 0);
    req = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table; the first vector also shows the pointer reset to 0.
    for (int v = 0; v < 8; v++)
      txn(vt[v].req, vt[v].cmd, vt[v].idx, vt[v].fz,
          vt[v].eg, vt[v].eerr, 1'b0);

    // Randomized transactions against the round-robin model.
    for (int t = 0; t < 200; t++) begin
      rq = 4'($urandom_range(0, 15));
      cm = 4'($urandom);
      ix = 12'($urandom);
      f  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      eg = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (eg < 0 && rq[(m_rr + i) % NREQ])
          eg = (m_rr + i) % NREQ;
      end
      eerr = 1'b0;
      if (eg >= 0) begin
        fi   = int'(ix[eg*3 +: 3]);
        eerr = f[fi] && cm[eg];
      end
      txn(rq, cm, ix, f, eg, eerr, 1'b1);
    end

    req = 4'b0000;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
